fifo_wptr_full: RTL
===================

# fifo_wptr_full

Write-side pointer and full-flag generator for the asynchronous FIFO. It is the counterpart of the read-pointer/empty logic and lives entirely in the write clock domain. It produces:
- the binary memory write address and the memory write enable;
- the Gray-coded write pointer that is handed to the read-domain synchronizer;
- full, almost-full, fill-level and sticky-overflow status, computed against the read pointer after it has been synchronized into the write domain.

## Interface
Parameters:
- ADDR_WIDTH, 4, memory address width; FIFO depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AFULL_THRESH, 12, fill level at or above which W_afull asserts; legal range 1..2^ADDR_WIDTH.

Ports:
- W_CLK  in  1  write-domain clock; one clock only, all state changes on its rising edge.
- W_rst  in  1  reset, synchronous and active-high.
- W_inc  in  1  write request from the producer.
- Wq2_rptr  in  ADDR_WIDTH+1  Gray read pointer, already two-flop synchronized to W_CLK.
- W_ovf_clr  in  1  clears the sticky overflow flag.
- W_en  out  1  memory write enable = W_inc & ~W_full (combinational).
- W_Addr  out  ADDR_WIDTH  binary memory write address (low bits of the binary pointer).
- W_ptr  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
- W_full  out  1  registered full flag.
- W_afull  out  1  registered almost-full flag.
- W_level  out  ADDR_WIDTH+1  registered fill level, range 0..2^ADDR_WIDTH.
- W_ovf  out  1  sticky overflow flag: a write was attempted while full.

## Operation
- Binary pointer: wbin_next = wbin + W_en, modulo 2^(ADDR_WIDTH+1). Gray conversion: wgray_next = (wbin_next >> 1) ^ wbin_next.
- Full flag. Define full_val as wgray_next == {~Wq2_rptr[MSB:MSB-1], Wq2_rptr[MSB-2:0]}, i.e. the top two bits inverted and the rest equal.
- Fill level:
  - rbin = gray2bin(Wq2_rptr);
  - level_next = wbin_next − rbin, modulo 2^(ADDR_WIDTH+1);
  - afull_val = (level_next >= AFULL_THRESH).
- Registered every cycle: wbin <= wbin_next, W_ptr <= wgray_next, W_full <= full_val, W_level <= level_next, W_afull <= afull_val.
- Overflow:
  - set when W_inc & W_full;
  - cleared by W_ovf_clr;
  - if set and clear occur in the same cycle, set wins.
- Writes while full are dropped: W_en = 0 and the pointer holds.
- Flags are pessimistic. Read progress is seen only after synchronizer latency, so W_full and W_level may overstate occupancy but never understate it.
- Reset (W_rst = 1 at an edge) gives W_full = 0, W_afull = 0, W_ptr = 0, W_Addr = 0, W_level = 0, W_ovf = 0. Reset overrides any write in the same cycle. W_en is still W_inc & ~W_full, which is combinational, so the memory may be written during reset; the pointer does not advance.

## Timing
- Write accepted at edge N: W_ptr, W_Addr and W_level update at edge N. W_full and W_afull reflect that write after edge N; there is no extra cycle.
- The write that fills the FIFO asserts W_full in the very next cycle, so a back-to-back write is blocked.
- A change on Wq2_rptr affects W_full, W_afull and W_level one edge later. End-to-end release after a real read is therefore about 3 W_CLK cycles.
- Wrap-around:
  - W_Addr wraps 2^ADDR_WIDTH−1 → 0;
  - the pointer wraps 2^(ADDR_WIDTH+1)−1 → 0;
  - level arithmetic stays correct across the wrap.
- Simultaneous write and read-pointer advance: level_next includes both effects, so the level is unchanged.
- W_ptr changes by at most one Gray bit per W_CLK.

## Structure
- The shared package fifo_cdc_pkg holds:
  - the default ADDR_WIDTH;
  - the bin2gray and gray2bin functions, which the read-pointer block also uses;
  - the pointer-width helper constant.
- Sub-module fifo_gray2bin: a parameterized XOR-prefix Gray-to-binary converter, instantiated for Wq2_rptr.
- Everything else is flat in this block.

## Test plan
All cases use ADDR_WIDTH = 4 and AFULL_THRESH = 12.
- Fill from empty: W_rst, then 16 consecutive W_inc with Wq2_rptr = 0 → W_Addr steps 0..15, W_level = 16, W_ptr = 5'b11000, W_full = 1 after the 16th write, W_afull = 1 after the 12th write.
- Write while full: in the full state above, W_inc = 1 → W_en = 0, W_ptr stays 5'b11000, W_ovf = 1. W_ovf_clr pulse → W_ovf = 0. Set and clear in the same cycle → W_ovf stays 1.
- Release: in the full state, drive Wq2_rptr = 5'b00001 (binary 1) → W_full = 0 and W_level = 15 one edge later; W_afull stays 1.
- Wrap: 40 writes with Wq2_rptr tracking the Gray write pointer delayed 2 cycles → W_full never asserts, W_ptr passes 5'b10000 (binary 31) → 5'b00000, W_Addr 15 → 0, W_level ≤ 3 throughout.
- Simultaneous: W_inc = 1 in the same cycle as Wq2_rptr advances by one → W_level unchanged, W_ptr advances by one.
- Mid-operation reset: after 5 writes, assert W_rst in a cycle where W_inc = 1 → next cycle all outputs are 0 and the write is not counted. The first write after reset uses W_Addr = 0.

Source files
------------

// File: rtl/fifo_cdc_pkg.sv
// Shared definitions for the asynchronous FIFO pointer logic.
//
// Contents:
//   FifoAddrWidth - default memory address width (depth = 2**FifoAddrWidth)
//   FifoPtrWidth  - default pointer width; one extra bit tells a full FIFO from an empty one
//   bin2gray      - binary to reflected-Gray conversion
//   gray2bin      - reflected-Gray to binary conversion
// The functions work on 32-bit values. Callers zero-extend narrower pointers on the way in
// and truncate on the way out; both conversions are exact for any narrower width.
package fifo_cdc_pkg;

  localparam int unsigned FifoAddrWidth = 4;
  localparam int unsigned FifoPtrWidth  = FifoAddrWidth + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int i = 1; i < 32; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Parameterised Gray-to-binary converter (purely combinational).
//
// Parameters:
//   Width  - pointer width in bits
// Ports:
//   gray_i - Gray-coded input
//   bin_o  - binary equivalent; bit i is the XOR-reduction of gray_i[Width-1:i]
module fifo_gray2bin #(
  parameter int unsigned Width = 5
) (
  input  logic [Width-1:0] gray_i,
  output logic [Width-1:0] bin_o
);

  for (genvar i = 0; i < Width; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[Width-1:i];
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and status generator for the asynchronous FIFO. It lives entirely in
// the write clock domain.
//
// Parameters:
//   ADDR_WIDTH   - memory address width; depth = 2**ADDR_WIDTH and pointers are
//                  ADDR_WIDTH+1 bits wide. Must be at least 2.
//   AFULL_THRESH - fill level at or above which W_afull asserts (1..2**ADDR_WIDTH)
// Ports:
//   W_CLK     - write-domain clock
//   W_rst     - synchronous, active-high reset
//   W_inc     - write request from the producer
//   Wq2_rptr  - Gray read pointer, already synchronised into W_CLK
//   W_ovf_clr - clears the sticky overflow flag
//   W_en      - memory write enable (combinational, W_inc & ~W_full)
//   W_Addr    - binary memory write address
//   W_ptr     - registered Gray write pointer, sent to the read-domain synchroniser
//   W_full    - registered full flag
//   W_afull   - registered almost-full flag
//   W_level   - registered fill level, 0..2**ADDR_WIDTH
//   W_ovf     - sticky flag: a write was attempted while full
//
// The status flags use the synchronised read pointer, so they lag real reads by the
// synchroniser latency. As a result they may overstate occupancy but never understate it.
module fifo_wptr_full
  import fifo_cdc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = FifoAddrWidth,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                  W_CLK,
  input  logic                  W_rst,
  input  logic                  W_inc,
  input  logic [ADDR_WIDTH:0]   Wq2_rptr,
  input  logic                  W_ovf_clr,
  output logic                  W_en,
  output logic [ADDR_WIDTH-1:0] W_Addr,
  output logic [ADDR_WIDTH:0]   W_ptr,
  output logic                  W_full,
  output logic                  W_afull,
  output logic [ADDR_WIDTH:0]   W_level,
  output logic                  W_ovf
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;
  localparam logic [PtrW-1:0] AfullThr = PtrW'(AFULL_THRESH);

  logic [PtrW-1:0] wbin_q, wbin_d;
  logic [PtrW-1:0] wgray_q, wgray_d;
  logic [PtrW-1:0] level_q, level_d;
  logic            full_q, full_d;
  logic            afull_q, afull_d;
  logic            ovf_q, ovf_d;

  logic [PtrW-1:0] rbin;
  logic [PtrW-1:0] rptr_full_cmp;

  // Read pointer in binary, used only for the fill level.
  fifo_gray2bin #(
    .Width (PtrW)
  ) u_rptr_gray2bin (
    .gray_i (Wq2_rptr),
    .bin_o  (rbin)
  );

  // Writes while full are dropped. The enable stays live during reset, but the
  // pointer does not move because reset takes priority below.
  assign W_en = W_inc & ~full_q;

  always_comb begin
    wbin_d  = wbin_q + PtrW'(W_en);
    wgray_d = PtrW'(bin2gray(32'(wbin_d)));

    // Full when the next write pointer is one lap ahead of the read pointer. In Gray
    // code, that means the top two bits are inverted and the rest are equal.
    rptr_full_cmp = {~Wq2_rptr[PtrW-1 -: 2], Wq2_rptr[PtrW-3:0]};
    full_d        = (wgray_d == rptr_full_cmp);

    // Modular subtraction stays correct across pointer wrap-around.
    level_d = wbin_d - rbin;
    afull_d = (level_d >= AfullThr);

    // If set and clear occur in the same cycle, the set wins.
    ovf_d = (W_inc & full_q) | (ovf_q & ~W_ovf_clr);
  end

  always_ff @(posedge W_CLK) begin
    if (W_rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign W_Addr  = wbin_q[ADDR_WIDTH-1:0];
  assign W_ptr   = wgray_q;
  assign W_full  = full_q;
  assign W_afull = afull_q;
  assign W_level = level_q;
  assign W_ovf   = ovf_q;

  // Outside reset, the Gray pointer must move by at most one bit per clock,
  // otherwise the read-domain synchroniser could capture a corrupt value.
  gray_step_a : assert property (@(posedge W_CLK) disable iff (W_rst)
    !$past(W_rst) |-> ($countones(W_ptr ^ $past(W_ptr)) <= 1));

endmodule
